// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// Sends one command byte followed by iNUM_BYTES data bytes; data bytes are
// full duplex, command-byte MISO bits are discarded.
module spi_master #(
  parameter int CLK_HALF = 4
) (
  input  logic       iCLK,
  input  logic       iRESET_n,
  input  logic       iSTART,
  input  logic [7:0] iCMD,
  input  logic [7:0] iNUM_BYTES,
  input  logic [7:0] iTX_BYTE,
  output logic       oTX_ACK,
  output logic [7:0] oRX_BYTE,
  output logic       oRX_VALID,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oSPI_CLK,
  output logic       oSPI_SS_n,
  output logic       oSPI_MOSI,
  input  logic       iSPI_MISO
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SCK_HI = 3'd2;
  localparam logic [2:0] S_SCK_LO = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             data_q, data_d;       // past the command byte
  logic             last_q, last_d;       // final bit shifted, heading for HOLD
  logic             rx_pend_q, rx_pend_d; // data byte complete, publish next cycle
  logic             sclk_q, sclk_d;
  logic             ss_n_q, ss_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_ack_q, tx_ack_d;
  logic             rx_valid_q, rx_valid_d;
  logic             div_last;
  logic             go_hi;

  assign div_last = (div_q == DIV_LAST);

  assign oTX_ACK   = tx_ack_q;
  assign oRX_BYTE  = rx_byte_q;
  assign oRX_VALID = rx_valid_q;
  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oSPI_CLK  = sclk_q;
  assign oSPI_SS_n = ss_n_q;
  assign oSPI_MOSI = mosi_q;

  // Next-state, shift-register and registered-output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    data_d     = data_q;
    last_d     = last_q;
    rx_pend_d  = 1'b0;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;
    go_hi      = 1'b0;

    if (state_q == S_IDLE) div_d = '0;
    else if (div_last)     div_d = '0;
    else                   div_d = div_q + DIV_W'(1);

    if (rx_pend_q) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d    = S_SETUP;
          shift_d    = iCMD;
          byte_cnt_d = iNUM_BYTES;
          bit_cnt_d  = '0;
          data_d     = 1'b0;
          last_d     = 1'b0;
          mosi_d     = iCMD[7];
          ss_n_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_SETUP: begin
        if (div_last) go_hi = 1'b1;
      end
      S_SCK_HI: begin
        if (div_last) begin
          state_d   = S_SCK_LO;
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            shift_d = {shift_q[6:0], 1'b0};
            mosi_d  = shift_q[6];
          end else if (byte_cnt_q != 8'd0) begin
            shift_d    = iTX_BYTE;
            mosi_d     = iTX_BYTE[7];
            tx_ack_d   = 1'b1;
            byte_cnt_d = byte_cnt_q - 8'd1;
            data_d     = 1'b1;
          end else begin
            last_d = 1'b1;
          end
        end
      end
      S_SCK_LO: begin
        if (div_last) begin
          if (last_q) state_d = S_HOLD;
          else        go_hi   = 1'b1;
        end
      end
      S_HOLD: begin
        if (div_last) begin
          state_d = S_GAP;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (div_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Rising SCLK edge: MISO is captured on the same clock that raises SCLK
    if (go_hi) begin
      state_d    = S_SCK_HI;
      sclk_d     = 1'b1;
      rx_shift_d = {rx_shift_q[6:0], iSPI_MISO};
      rx_pend_d  = data_q && (bit_cnt_q == 3'd7);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge iCLK) begin
    if (!iRESET_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      data_q     <= 1'b0;
      last_q     <= 1'b0;
      rx_pend_q  <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rx_pend_q  <= rx_pend_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_HALF=4 and 1),
// each with a mode-0 slave model and scoreboard queues.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- instance A: CLK_HALF = 4 ----------------
  logic       a_start = 1'b0;
  logic [7:0] a_cmd = '0, a_num = '0, a_tx = '0;
  logic       a_ack, a_rxv, a_busy, a_done, a_sclk, a_ss, a_mosi;
  logic       a_miso = 1'b0;
  logic [7:0] a_rxb;

  spi_master #(.CLK_HALF(4)) u_a (
    .iCLK(clk), .iRESET_n(rst_n), .iSTART(a_start), .iCMD(a_cmd),
    .iNUM_BYTES(a_num), .iTX_BYTE(a_tx), .oTX_ACK(a_ack), .oRX_BYTE(a_rxb),
    .oRX_VALID(a_rxv), .oBUSY(a_busy), .oDONE(a_done), .oSPI_CLK(a_sclk),
    .oSPI_SS_n(a_ss), .oSPI_MOSI(a_mosi), .iSPI_MISO(a_miso)
  );

  logic [7:0] a_txq[$], a_resp[$], a_exp_slave[$], a_exp_rx[$];
  int         a_exp_len[$], a_exp_n[$];
  logic       a_prev_ss = 1'b1, a_prev_sclk = 1'b0;
  logic [7:0] a_sin = '0, a_sout = '0;
  int a_sshigh = 0, a_sslow = 0, a_rise = 0, a_bits = 0;
  int a_acks = 0, a_rxvs = 0, a_dones = 0, a_n = 0;

  // Slave model and scoreboard for A, sampled on the falling iCLK edge
  always @(negedge clk) begin
    if (a_prev_ss && !a_ss) begin
      chk("A_ss_gap_min", (a_sshigh >= 5) ? 1 : 0, 1);
      a_sshigh = 0; a_sslow = 0; a_rise = 0; a_bits = 0; a_acks = 0; a_rxvs = 0;
      a_sout = 8'hFF;
      a_miso = 1'b1;
      a_tx = (a_txq.size() != 0) ? a_txq.pop_front() : 8'h00;
    end
    if (a_ss) a_sshigh++; else a_sslow++;
    if (!a_ss && a_sclk && !a_prev_sclk) begin
      a_sin = {a_sin[6:0], a_mosi};
      a_bits++; a_rise++;
      if (a_bits % 8 == 0) begin
        if (a_exp_slave.size() == 0) chk("A_slave_extra_byte", 1, 0);
        else chk("A_slave_rx", int'(a_sin), int'(a_exp_slave.pop_front()));
      end
    end
    if (!a_ss && !a_sclk && a_prev_sclk) begin
      if (a_bits % 8 == 0) a_sout = (a_resp.size() != 0) ? a_resp.pop_front() : 8'h00;
      else a_sout = {a_sout[6:0], 1'b0};
      a_miso = a_sout[7];
    end
    if (a_ack) begin
      a_acks++;
      a_tx = (a_txq.size() != 0) ? a_txq.pop_front() : 8'h00;
    end
    if (a_rxv) begin
      a_rxvs++;
      if (a_exp_rx.size() == 0) chk("A_rx_extra", 1, 0);
      else chk("A_rx_byte", int'(a_rxb), int'(a_exp_rx.pop_front()));
    end
    if (a_done) begin
      a_dones++;
      chk("A_done_ss_high", int'(a_ss), 1);
      if (a_exp_len.size() == 0) chk("A_done_extra", 1, 0);
      else begin
        chk("A_ss_low_cycles", a_sslow, a_exp_len.pop_front());
        a_n = a_exp_n.pop_front();
        chk("A_sclk_rises", a_rise, 8 * (1 + a_n));
        chk("A_tx_acks", a_acks, a_n);
        chk("A_rx_valids", a_rxvs, a_n);
      end
    end
    a_prev_ss = a_ss;
    a_prev_sclk = a_sclk;
  end

  // ---------------- instance B: CLK_HALF = 1, MISO tied low ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_cmd = '0, b_num = '0, b_tx = '0;
  logic       b_ack, b_rxv, b_busy, b_done, b_sclk, b_ss, b_mosi;
  logic       b_miso;
  logic [7:0] b_rxb;
  assign b_miso = 1'b0;

  spi_master #(.CLK_HALF(1)) u_b (
    .iCLK(clk), .iRESET_n(rst_n), .iSTART(b_start), .iCMD(b_cmd),
    .iNUM_BYTES(b_num), .iTX_BYTE(b_tx), .oTX_ACK(b_ack), .oRX_BYTE(b_rxb),
    .oRX_VALID(b_rxv), .oBUSY(b_busy), .oDONE(b_done), .oSPI_CLK(b_sclk),
    .oSPI_SS_n(b_ss), .oSPI_MOSI(b_mosi), .iSPI_MISO(b_miso)
  );

  logic [7:0] b_txq[$], b_exp_slave[$], b_exp_rx[$];
  logic       b_prev_ss = 1'b1, b_prev_sclk = 1'b0;
  logic [7:0] b_sin = '0;
  int b_sslow = 0, b_rise = 0, b_bits = 0, b_tog = 0, b_acks = 0, b_rxvs = 0, b_dones = 0;

  // Slave model and scoreboard for B
  always @(negedge clk) begin
    if (b_prev_ss && !b_ss) begin
      b_sslow = 0; b_rise = 0; b_bits = 0; b_tog = 0; b_acks = 0; b_rxvs = 0;
      b_tx = (b_txq.size() != 0) ? b_txq.pop_front() : 8'h00;
    end
    if (!b_ss) b_sslow++;
    if (b_sclk != b_prev_sclk) b_tog++;
    if (!b_ss && b_sclk && !b_prev_sclk) begin
      b_sin = {b_sin[6:0], b_mosi};
      b_bits++; b_rise++;
      if (b_bits % 8 == 0) begin
        if (b_exp_slave.size() == 0) chk("B_slave_extra_byte", 1, 0);
        else chk("B_slave_rx", int'(b_sin), int'(b_exp_slave.pop_front()));
      end
    end
    if (b_ack) begin
      b_acks++;
      b_tx = (b_txq.size() != 0) ? b_txq.pop_front() : 8'h00;
    end
    if (b_rxv) begin
      b_rxvs++;
      if (b_exp_rx.size() == 0) chk("B_rx_extra", 1, 0);
      else chk("B_rx_byte", int'(b_rxb), int'(b_exp_rx.pop_front()));
    end
    if (b_done) begin
      b_dones++;
      chk("B_ss_low_cycles", b_sslow, 34);
      chk("B_sclk_rises", b_rise, 16);
      chk("B_sclk_toggles", b_tog, 32);
      chk("B_tx_acks", b_acks, 1);
      chk("B_rx_valids", b_rxvs, 1);
    end
    b_prev_ss = b_ss;
    b_prev_sclk = b_sclk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_byte(input logic [7:0] tx, input logic [7:0] resp);
    a_txq.push_back(tx);
    a_resp.push_back(resp);
    a_exp_slave.push_back(tx);
    a_exp_rx.push_back(resp);
  endtask

  // Expectations for the command byte must be pushed before calling a_byte
  task automatic a_expect_cmd(input logic [7:0] cmd, input int n);
    a_exp_slave.push_back(cmd);
    a_exp_len.push_back(4 * (2 + 16 * (1 + n)));
    a_exp_n.push_back(n);
  endtask

  task automatic a_go(input logic [7:0] cmd, input logic [7:0] n);
    a_cmd = cmd; a_num = n; a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("A_start_busy", int'(a_busy), 1);
    chk("A_start_ss", int'(a_ss), 0);
    chk("A_start_mosi", int'(a_mosi), int'(cmd[7]));
    chk("A_start_sclk", int'(a_sclk), 0);
  endtask

  task automatic a_wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      step();
      if (a_done) got = 1'b1;
    end
    chk(tag, int'(got), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit bad;
    int d0;

    // Reset held with iSTART high: nothing may happen
    rst_n = 1'b0; a_start = 1'b1; a_cmd = 8'hFF; a_num = 8'd3;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_ss !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) bad = 1'b1;
    end
    chk("rst_quiet", int'(bad), 0);
    chk("rst_ss", int'(a_ss), 1);
    chk("rst_sclk", int'(a_sclk), 0);
    chk("rst_mosi", int'(a_mosi), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_ack_rxv", int'({a_ack, a_rxv}), 0);
    chk("rst_rx_byte", int'(a_rxb), 0);
    chk("rst_b_ss", int'(b_ss), 1);

    // Idle after reset release
    a_start = 1'b0; rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_ss !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_quiet", int'(bad), 0);

    // Command only: 0xA8, N=0
    a_expect_cmd(8'hA8, 0);
    a_go(8'hA8, 8'd0);
    a_wait_done("A_cmd_only_done");
    chk("A_done_mosi_low", int'(a_mosi), 0);
    chk("A_gap_busy", int'(a_busy), 1);
    repeat (3) step();
    chk("A_gap_end_busy", int'(a_busy), 1);
    step();
    chk("A_idle_busy", int'(a_busy), 0);

    // Two data bytes with a start pulse while busy
    a_expect_cmd(8'h88, 2);
    a_byte(8'h5A, 8'h3C);
    a_byte(8'hC3, 8'hF0);
    a_go(8'h88, 8'd2);
    repeat (30) step();
    a_cmd = 8'hFF; a_num = 8'd9; a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_wait_done("A_two_byte_done");
    repeat (10) step();
    chk("A_last_rx_byte", int'(a_rxb), 8'hF0);

    // CLK_HALF=1, one byte of 0xFF, MISO low
    b_txq.push_back(8'hFF);
    b_exp_slave.push_back(8'h90);
    b_exp_slave.push_back(8'hFF);
    b_exp_rx.push_back(8'h00);
    b_cmd = 8'h90; b_num = 8'd1; b_start = 1'b1;
    step();
    b_start = 1'b0;
    bad = 1'b1;
    for (int i = 0; i < 200 && bad; i++) begin
      step();
      if (b_done) bad = 1'b0;
    end
    chk("B_done_seen", int'(bad), 0);
    repeat (4) step();
    chk("B_idle_busy", int'(b_busy), 0);

    // Reset during bit 3 of the first data byte
    a_expect_cmd(8'h88, 1);
    a_byte(8'h5A, 8'h3C);
    a_go(8'h88, 8'd1);
    bad = 1'b1;
    for (int i = 0; i < 500 && bad; i++) begin
      step();
      if (a_rise == 11) bad = 1'b0;
    end
    chk("A_reach_bit3", int'(bad), 0);
    d0 = a_dones;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("A_abort_ss", int'(a_ss), 1);
    chk("A_abort_sclk", int'(a_sclk), 0);
    chk("A_abort_busy", int'(a_busy), 0);
    repeat (20) step();
    chk("A_abort_no_done", a_dones, d0);
    a_exp_slave.delete(); a_exp_rx.delete(); a_txq.delete(); a_resp.delete();
    a_exp_len.delete(); a_exp_n.delete();

    // Normal transaction after the abort
    a_expect_cmd(8'h88, 1);
    a_byte(8'h77, 8'h81);
    a_go(8'h88, 8'd1);
    a_wait_done("A_after_abort_done");

    // iSTART held high: back-to-back command-only transactions
    repeat (10) step();
    for (int i = 0; i < 3; i++) a_expect_cmd(8'h50, 0);
    d0 = a_dones;
    a_cmd = 8'h50; a_num = 8'd0; a_start = 1'b1;
    for (int i = 0; i < 3; i++) a_wait_done("A_held_start_done");
    a_start = 1'b0;
    repeat (40) step();
    chk("A_held_done_count", a_dones - d0, 3);
    chk("A_held_idle_busy", int'(a_busy), 0);

    // Everything expected must have been consumed
    chk("A_q_slave_empty", a_exp_slave.size(), 0);
    chk("A_q_rx_empty", a_exp_rx.size(), 0);
    chk("A_q_len_empty", a_exp_len.size(), 0);
    chk("B_q_rx_empty", b_exp_rx.size() + b_exp_slave.size(), 0);
    chk("B_done_count", b_dones, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
